pool_flatten: RTL and testbench
===============================

POOL_FLATTEN -- requirements
Module: pool_flatten

Interface
REQ-001 Parameter DW, default 20: width of layer-memory data words.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clock clk.
REQ-004 start  input  1  one-cycle request to begin a pooling/flatten pass; sampled only in IDLE.
REQ-005 busy  output  1  high from the cycle after start is accepted until done.
REQ-006 done  output  1  one-cycle pulse after the last write of a pass.
REQ-007 crd  output  1  layer-memory read strobe.
REQ-008 caddr_rd  output  12  read address {row[5:0],col[5:0]}.
REQ-009 cdata_rd  input  DW  read data, valid one clock after crd/caddr_rd/csel are driven.
REQ-010 cwr  output  1  layer-memory write strobe.
REQ-011 caddr_wr  output  12  write address.
REQ-012 cdata_wr  output  DW  write data.
REQ-013 csel  output  3  memory select: 001 L0-k0, 010 L0-k1, 011 L1-k0, 100 L1-k1, 101 L2 flatten, 000 none.

Function
REQ-014 Block reads the two 64x64 ReLU'd L0 maps and produces two 32x32 2x2-max-pooled L1 maps, plus an interleaved 2048-entry L2 flatten.
REQ-015 Pooled pixels are visited in raster order (pr,pc) = (0,0)..(31,31); for each pixel, kernel 0 first, then kernel 1.
REQ-016 States: IDLE, RD0..RD3, CAP, WR_L1, WR_L2, DONE.
REQ-017 IDLE -> RD0 on start; RD0->RD1->RD2->RD3->CAP->WR_L1; WR_L1 -> WR_L2; WR_L2 -> RD0 (next kernel/pixel), or -> DONE after pixel (31,31) kernel 1; DONE -> IDLE.
REQ-018 RD0..RD3 drive crd=1, csel = 001 (k0) or 010 (k1), and caddr_rd = {2pr,2pc}, {2pr,2pc+1}, {2pr+1,2pc}, {2pr+1,2pc+1} respectively.
REQ-019 Running max is captured from cdata_rd in RD1, RD2, RD3, and CAP; the first capture loads the value, later captures replace it only if strictly greater.
REQ-020 Comparison is unsigned over DW bits; ties keep the held value (same numeric result).
REQ-021 WR_L1: cwr=1, csel = 011 (k0) or 100 (k1), caddr_wr = {2'b00,pr[4:0],pc[4:0]}, cdata_wr = max.
REQ-022 WR_L2: cwr=1, csel=101, caddr_wr = {1'b0,pr[4:0],pc[4:0],k}, cdata_wr = same max.
REQ-023 crd and cwr are never high in the same cycle; outside RD states crd=0; outside WR states cwr=0.
REQ-024 Outside RD/WR states, csel=000; caddr and data outputs hold their last values.
REQ-025 Throughput is 7 cycles per (pixel,kernel); a full pass is 14336 cycles from the first RD0 to the last WR_L2; done is asserted in the following cycle.
REQ-026 busy falls in the same cycle done is high; start during busy or DONE is ignored.

Reset
REQ-027 On reset, all outputs go low (busy, done, crd, cwr, csel=000, caddr_rd, caddr_wr, cdata_wr all zero) and the FSM, counters, and max register clear to IDLE/0.
REQ-028 Reset asserted mid-pass aborts the pass immediately, with no further reads or writes; a subsequent start performs a complete fresh pass.

Configuration
REQ-029 Macro POOL_FLATTEN_FLAT_EN: when defined, WR_L2 exists as in REQ-017/022.
REQ-030 When POOL_FLATTEN_FLAT_EN is undefined, WR_L2 is removed, WR_L1 transitions directly to RD0/DONE, csel=101 never appears, and a pass is 6 cycles per (pixel,kernel), 12288 cycles total.

Verification
REQ-031 Set L0-k0[a] = a (20-bit) and pulse start -> L1-k0[0] = 65, L1-k0[1023] = 4095, and L1-k0[33] = 195.
REQ-032 Fill L0-k1 with 20'h00005 except L0-k1[130] = 20'hFFFFF -> L1-k1[33] = 20'hFFFFF and every other L1-k1 entry = 20'h00005.
REQ-033 Set all four inputs of pixel (0,0) k0 to 20'h80000 -> L1-k0[0] = 20'h80000 (unsigned compare, tie kept).
REQ-034 FLAT_EN defined -> L2[0] = L1-k0[0], L2[1] = L1-k1[0], L2[2047] = L1-k1[1023]; single done pulse 14337 cycles after the first RD0.
REQ-035 Assert reset at cycle 500 of a pass -> next edge all outputs zero and no cwr; re-pulse start -> full, correct pass with one done.
REQ-036 FLAT_EN undefined, start held high throughout -> exactly one pass, no csel=101 cycles, done 12289 cycles after the first RD0, start ignored while busy.

Source files
------------

// File: rtl/pool_flatten.sv
// 2x2 max-pool of two 64x64 layer-0 maps into two 32x32 layer-1 maps.
// Define POOL_FLATTEN_FLAT_EN to also emit the interleaved 2048-entry layer-2 flatten.
module pool_flatten #(
  parameter int unsigned DW = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_crd,
  output logic [11:0]   o_caddr_rd,
  input  logic [DW-1:0] i_cdata_rd,
  output logic          o_cwr,
  output logic [11:0]   o_caddr_wr,
  output logic [DW-1:0] o_cdata_wr,
  output logic [2:0]    o_csel
);

  typedef enum logic [3:0] {
    StIdle, StRd0, StRd1, StRd2, StRd3, StCap, StWrL1, StWrL2, StDone
  } state_t;

  state_t        r_state, w_state_next;
  logic [10:0]   r_idx;  // {pr, pc, k}
  logic [DW-1:0] r_max;
  logic          r_start_d;
  logic [11:0]   r_caddr_rd, r_caddr_wr;
  logic [DW-1:0] r_cdata_wr;

  logic [4:0]    w_pr, w_pc;
  logic          w_k, w_last, w_advance;
  logic          w_rd, w_wr, w_busy, w_done;
  logic [2:0]    w_csel;
  logic [11:0]   w_rd_addr, w_wr_addr;
  logic [DW-1:0] w_wr_data;

  assign w_pr   = r_idx[10:6];
  assign w_pc   = r_idx[5:1];
  assign w_k    = r_idx[0];
  assign w_last = &r_idx;

  always_comb begin
    w_state_next = r_state;
    w_rd         = 1'b0;
    w_wr         = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_advance    = 1'b0;
    w_csel       = 3'b000;
    w_rd_addr    = r_caddr_rd;
    w_wr_addr    = r_caddr_wr;
    w_wr_data    = r_cdata_wr;
    unique case (r_state)
      StIdle: begin
        // Rising edge only, so a start held high yields a single pass.
        if (i_start && !r_start_d) w_state_next = StRd0;
      end
      StRd0, StRd1, StRd2, StRd3: begin
        w_busy    = 1'b1;
        w_rd      = 1'b1;
        w_csel    = w_k ? 3'b010 : 3'b001;
        w_rd_addr = {w_pr, (r_state == StRd2) || (r_state == StRd3),
                     w_pc, (r_state == StRd1) || (r_state == StRd3)};
        unique case (r_state)
          StRd0:   w_state_next = StRd1;
          StRd1:   w_state_next = StRd2;
          StRd2:   w_state_next = StRd3;
          default: w_state_next = StCap;
        endcase
      end
      StCap: begin
        w_busy       = 1'b1;
        w_state_next = StWrL1;
      end
      StWrL1: begin
        w_busy    = 1'b1;
        w_wr      = 1'b1;
        w_csel    = w_k ? 3'b100 : 3'b011;
        w_wr_addr = {2'b00, w_pr, w_pc};
        w_wr_data = r_max;
`ifdef POOL_FLATTEN_FLAT_EN
        w_state_next = StWrL2;
`else
        w_advance    = 1'b1;
        w_state_next = w_last ? StDone : StRd0;
`endif
      end
`ifdef POOL_FLATTEN_FLAT_EN
      StWrL2: begin
        w_busy       = 1'b1;
        w_wr         = 1'b1;
        w_csel       = 3'b101;
        w_wr_addr    = {1'b0, r_idx};
        w_wr_data    = r_max;
        w_advance    = 1'b1;
        w_state_next = w_last ? StDone : StRd0;
      end
`endif
      StDone: begin
        w_done       = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_max      <= '0;
      r_start_d  <= 1'b0;
      r_caddr_rd <= '0;
      r_caddr_wr <= '0;
      r_cdata_wr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_start_d  <= i_start;
      r_caddr_rd <= w_rd_addr;
      r_caddr_wr <= w_wr_addr;
      r_cdata_wr <= w_wr_data;
      if (r_state == StIdle) begin
        r_idx <= '0;
      end else if (w_advance) begin
        r_idx <= r_idx + 11'd1;
      end
      // Read data trails its address by one cycle: RD0's word arrives in RD1.
      if (r_state == StRd1) begin
        r_max <= i_cdata_rd;
      end else if ((r_state == StRd2 || r_state == StRd3 || r_state == StCap) &&
                   (i_cdata_rd > r_max)) begin
        r_max <= i_cdata_rd;
      end
    end
  end

  assign o_busy     = w_busy;
  assign o_done     = w_done;
  assign o_crd      = w_rd;
  assign o_cwr      = w_wr;
  assign o_csel     = w_csel;
  assign o_caddr_rd = w_rd_addr;
  assign o_caddr_wr = w_wr_addr;
  assign o_cdata_wr = w_wr_data;

endmodule

// File: tb/tb_pool_flatten.sv
// Scoreboard bench for pool_flatten: memory model, expected-write queue, timing checks.
// Works in both builds (POOL_FLATTEN_FLAT_EN defined or not).
module tb_pool_flatten;
  localparam int DW = 20;
`ifdef POOL_FLATTEN_FLAT_EN
  localparam int CPK  = 7;
  localparam bit FLAT = 1'b1;
`else
  localparam int CPK  = 6;
  localparam bit FLAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] cdata_rd = '0;
  logic          busy, done, crd, cwr;
  logic [11:0]   caddr_rd, caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;

  pool_flatten #(.DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (start),
    .o_busy     (busy),
    .o_done     (done),
    .o_crd      (crd),
    .o_caddr_rd (caddr_rd),
    .i_cdata_rd (cdata_rd),
    .o_cwr      (cwr),
    .o_caddr_wr (caddr_wr),
    .o_cdata_wr (cdata_wr),
    .o_csel     (csel)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem0 [4096];
  logic [DW-1:0] mem1 [4096];
  logic [DW-1:0] l1k0 [1024];
  logic [DW-1:0] l1k1 [1024];
  logic [DW-1:0] l2   [2048];

  typedef struct packed {
    logic [2:0]    sel;
    logic [11:0]   addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int rd_cnt = 0;
  int pass_cyc = 0;
  int done_cnt = 0;
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Synchronous-read layer memory: data appears one clock after the strobe.
  always @(posedge clk) begin
    if (crd) cdata_rd <= (csel == 3'd1) ? mem0[caddr_rd] : mem1[caddr_rd];
  end

  function automatic logic [DW-1:0] pool_max(input bit k, input logic [4:0] pr,
                                             input logic [4:0] pc);
    logic [DW-1:0] m, v;
    m = '0;
    for (int s = 0; s < 4; s++) begin
      logic [11:0] a;
      a = {pr, s[1], pc, s[0]};
      v = k ? mem1[a] : mem0[a];
      if (v > m) m = v;
    end
    return m;
  endfunction

  task automatic push_pass();
    exp_q.delete();
    for (int i = 0; i < 2048; i++) begin
      logic [10:0] u;
      logic [DW-1:0] v;
      wr_t e;
      u = i[10:0];
      v = pool_max(u[0], u[10:6], u[5:1]);
      e.sel  = u[0] ? 3'd4 : 3'd3;
      e.addr = {2'b00, u[10:1]};
      e.data = v;
      exp_q.push_back(e);
      if (FLAT) begin
        e.sel  = 3'd5;
        e.addr = {1'b0, u};
        exp_q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    logic [12:0] c;
    if (mon_en) begin
      if (pass_cyc != 0) pass_cyc++;
      else if (crd) pass_cyc = 1;
      check("rd_wr_excl", {31'd0, crd & cwr}, 0);
      if (crd) begin
        c = rd_cnt[12:0];
        check("rd_addr", {20'd0, caddr_rd}, {20'd0, c[12:8], c[1], c[7:3], c[0]});
        check("rd_sel", {29'd0, csel}, c[2] ? 32'd2 : 32'd1);
        rd_cnt++;
      end else if (cwr) begin
        if (exp_q.size() == 0) begin
          check("extra_wr", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_sel", {29'd0, csel}, {29'd0, e.sel});
          check("wr_addr", {20'd0, caddr_wr}, {20'd0, e.addr});
          check("wr_data", {12'd0, cdata_wr}, {12'd0, e.data});
        end
        case (csel)
          3'd3:    l1k0[caddr_wr[9:0]] = cdata_wr;
          3'd4:    l1k1[caddr_wr[9:0]] = cdata_wr;
          3'd5:    l2[caddr_wr[10:0]]  = cdata_wr;
          default: ;
        endcase
      end else begin
        check("idle_sel", {29'd0, csel}, 0);
      end
      if (done) begin
        // Cycle 1 is the first RD0; done follows the last write.
        check("done_cyc", pass_cyc, 2048 * CPK + 1);
        check("busy_at_done", {31'd0, busy}, 0);
        done_cnt++;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, {26'd0, busy, done, crd, cwr, csel}, 0);
    check({tag, "_ardr"}, {20'd0, caddr_rd}, 0);
    check({tag, "_awr"}, {20'd0, caddr_wr}, 0);
    check({tag, "_dwr"}, {12'd0, cdata_wr}, 0);
  endtask

  task automatic begin_pass(input bit hold);
    push_pass();
    rd_cnt   = 0;
    pass_cyc = 0;
    done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 if (!hold) start = 1'b0;
  endtask

  task automatic run_pass(input bit hold);
    begin_pass(hold);
    for (int i = 0; i < 20000; i++) begin
      if (done_cnt != 0) break;
      @(posedge clk);
    end
    check("done_seen", {31'd0, done_cnt != 0}, 1);
    repeat (20) @(posedge clk);
    check("done_count", done_cnt, 1);
    check("q_empty", exp_q.size(), 0);
    check("rd_count", rd_cnt, 8192);
    #1 start = 1'b0;
  endtask

  initial begin
    int bad;
    for (int a = 0; a < 4096; a++) begin
      mem0[a] = DW'(a);
      mem1[a] = 20'h00005;
    end
    mem1[130] = 20'hFFFFF;

    repeat (3) @(posedge clk);
    #1 check_outputs_zero("rst");
    reset = 1'b0;
    mon_en = 1'b1;

    // Ramp map / single spike
    run_pass(1'b0);
    check("l1k0_0", {12'd0, l1k0[0]}, 65);
    check("l1k0_1023", {12'd0, l1k0[1023]}, 4095);
    check("l1k0_33", {12'd0, l1k0[33]}, 195);
    check("l1k1_33", {12'd0, l1k1[33]}, 32'hFFFFF);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (i != 33 && l1k1[i] !== 20'h00005) bad++;
    check("l1k1_rest", bad, 0);
    if (FLAT) begin
      check("l2_0", {12'd0, l2[0]}, 65);
      check("l2_1", {12'd0, l2[1]}, 5);
      check("l2_2047", {12'd0, l2[2047]}, 5);
    end

    // Random full-range data, tie at pixel (0,0) k0
    for (int a = 0; a < 4096; a++) begin
      mem0[a] = DW'($urandom);
      mem1[a] = DW'($urandom);
    end
    mem0[0] = 20'h80000; mem0[1] = 20'h80000; mem0[64] = 20'h80000; mem0[65] = 20'h80000;
    run_pass(1'b0);
    check("tie_max", {12'd0, l1k0[0]}, 32'h80000);

    // Abort at cycle 500, then a clean pass
    begin_pass(1'b0);
    for (int i = 0; i < 2000; i++) begin
      if (pass_cyc >= 500) break;
      @(posedge clk);
    end
    check("reached_500", {31'd0, pass_cyc >= 500}, 1);
    #1 reset = 1'b1;
    mon_en = 1'b0;
    #1 check_outputs_zero("abort");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 check_outputs_zero("abort_hold");
    end
    reset = 1'b0;
    mon_en = 1'b1;
    run_pass(1'b0);

    // Start held high for the whole pass and beyond
    run_pass(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
